hamming_dec_arbiter: RTL
========================

# hamming_dec_arbiter

Sequencing controller that shares one combinational Hamming(7,4) correction datapath between two codeword sources. It arbitrates round-robin between two valid/ready requesters and captures the granted codeword. It then runs syndrome and correction in registered steps and presents the decoded nibble, with its source tag and error flag, on a single valid/ready output. It sits between the two receive channels and the consumer of decoded data.

## Interface
Parameters:
- `CNT_W`, 8, width of per-source corrected-word counters (used only with `HAMMING_ERRCNT_EN`).

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in0_valid` / `in1_valid`  in  1  requester 0/1 holds a codeword.
- `in0_ready` / `in1_ready`  out  1  requester 0/1 codeword accepted this cycle.
- `in0_cw` / `in1_cw`  in  7  codeword, bit index k = Hamming position k+1.
- `out_valid`  out  1  decoded result available.
- `out_ready`  in  1  consumer accepts the result.
- `out_data`  out  4  corrected data, {cw[6],cw[5],cw[4],cw[2]}.
- `out_cw`  out  7  corrected codeword.
- `out_syndrome`  out  3  syndrome of the received word.
- `out_corrected`  out  1  syndrome was non-zero and one bit was flipped.
- `out_src`  out  1  requester that supplied the word.
- `err_cnt0` / `err_cnt1`  out  CNT_W  corrected words per source.

## Operation
- FSM states:
  - IDLE → SYND on any input handshake.
  - SYND → CORR unconditionally.
  - CORR → OUT unconditionally.
  - OUT → IDLE when `out_ready`=1.
- Arbitration in IDLE only. `rr_q` holds the last granted source.
  - If both valid, grant the source ≠ `rr_q`. Otherwise grant the single valid one.
  - `inN_ready` = (state==IDLE) & grant==N, combinational, and never both high.
  - On handshake: capture `cw_q`, `src_q`, and update `rr_q` to the granted source.
- SYND: register the syndrome into `synd_q`.
  - s0 = ^cw[0,2,4,6]
  - s1 = ^cw[1,2,5,6]
  - s2 = ^cw[3,4,5,6]
- CORR: drive `cw_q`/`synd_q` into the correction datapath and register its outputs.
  - Syndrome k≠0 flips bit k−1.
  - `out_corrected` = (synd_q≠0).
- OUT: result outputs hold stable while `out_valid`=1 and `out_ready`=0.
- No double-error detection: a 2-bit error decodes to a wrong nibble with `out_corrected`=1. This is required behaviour.
- Requesters in this block never see backpressure except through `inN_ready`. A requester must keep its valid and codeword stable until accepted.

## Timing
- Reset values:
  - state = IDLE.
  - `rr_q`=1, so requester 0 wins the first tie.
  - All result registers 0, `out_valid`=0, both readies 0 during reset, counters 0.
- Latency: input handshake at cycle T → `out_valid`=1 at T+3.
- Throughput: one word per 4 cycles when `out_ready` is tied high. Each extra stall cycle adds one.
- No input is accepted in SYND, CORR or OUT, so a new word cannot overlap a pending result.
- Reset asserted mid-operation: immediate return to reset values and the in-flight word is discarded. `out_valid` drops asynchronously.
- `out_ready` high outside OUT is ignored.

## Configuration
- `HAMMING_ERRCNT_EN` defined:
  - On each OUT→IDLE transfer with `out_corrected`=1, increment `err_cnt[src_q]`.
  - Counters saturate at 2^CNT_W−1 and clear only on reset.
- `HAMMING_ERRCNT_EN` undefined: the counters are not built and `err_cnt0`/`err_cnt1` are tied to 0.

## Structure
- Shared package `hamming_pkg` holds:
  - `cw_t` (logic [6:0]), `synd_t` (logic [2:0]), `nibble_t` (logic [3:0]).
  - FSM enum `dec_state_e` {IDLE, SYND, CORR, OUT}.
  - A `calc_syndrome(cw_t)` function.
  - Data-bit index constants 6, 5, 4, 2.
- One sub-module: the team's existing combinational corrector `correccion_error`, instantiated once in CORR's datapath. The arbiter, FSM, registers and counters live in `hamming_dec_arbiter`.

## Test plan
- Clean word: in0 sends 0x55 → at T+3 `out_data`=4'b1011, `out_syndrome`=0, `out_corrected`=0, `out_src`=0, `out_cw`=0x55.
- Single-bit error: in1 sends 0x45 (bit 4 flipped) → `out_syndrome`=3'b101, `out_cw`=0x55, `out_data`=4'b1011, `out_corrected`=1, `out_src`=1.
- Tie after reset: both valid with 0x55 and 0x45 → in0 is granted first. in1 is granted on the next IDLE. Outputs arrive in order src 0 then src 1, with no cycle where both readies are high.
- Backpressure: hold `out_ready`=0 for 5 cycles in OUT → outputs remain constant and `in0_ready`/`in1_ready` stay 0. Release → IDLE on the next cycle.
- Reset mid-flight: assert `rst_n`=0 in CORR → `out_valid`=0 and state IDLE. After release the next tie grants in0.
- With `HAMMING_ERRCNT_EN` and CNT_W=2: send five 0x45 words from in1 → `err_cnt1` reads 1,2,3,3,3 and `err_cnt0` stays 0.

Source files
------------

// File: rtl/hamming_pkg.sv
// Shared Hamming(7,4) types, FSM encoding, data-bit positions and syndrome helper.
package hamming_pkg;

   localparam int unsigned CW_W   = 7;
   localparam int unsigned SYND_W = 3;
   localparam int unsigned NIB_W  = 4;

   typedef logic [CW_W-1:0]   cw_t;
   typedef logic [SYND_W-1:0] synd_t;
   typedef logic [NIB_W-1:0]  nibble_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SYND = 2'd1,
      CORR = 2'd2,
      OUT  = 2'd3
   } dec_state_e;

   // Codeword positions carrying data bits d3..d0
   localparam int unsigned D3_IDX = 6;
   localparam int unsigned D2_IDX = 5;
   localparam int unsigned D1_IDX = 4;
   localparam int unsigned D0_IDX = 2;

   // Syndrome {s2,s1,s0}; a non-zero value k points at Hamming position k
   function automatic synd_t calc_syndrome(input cw_t cw);
      return {cw[3] ^ cw[4] ^ cw[5] ^ cw[6],
              cw[1] ^ cw[2] ^ cw[5] ^ cw[6],
              cw[0] ^ cw[2] ^ cw[4] ^ cw[6]};
   endfunction

endpackage

// File: rtl/correccion_error.sv
// Combinational single-bit corrector: flips bit (syndrome-1) and extracts the nibble.
module correccion_error
   import hamming_pkg::*;
(
   input  cw_t     i_cw,
   input  synd_t   i_synd,
   output cw_t     o_cw_c,
   output nibble_t o_data_c,
   output logic    o_corrected_c
);

   cw_t w_flip;

   // One-hot flip mask decoded from the syndrome (zero syndrome flips nothing)
   always_comb begin
      w_flip = '0;
      for (int k = 0; k < int'(CW_W); k++) begin
         w_flip[k] = (i_synd == SYND_W'(k + 1));
      end
   end

   assign o_cw_c        = i_cw ^ w_flip;
   assign o_data_c      = {o_cw_c[D3_IDX], o_cw_c[D2_IDX], o_cw_c[D1_IDX], o_cw_c[D0_IDX]};
   assign o_corrected_c = |i_synd;

endmodule

// File: rtl/hamming_dec_arbiter.sv
// Two-source round-robin front end sharing one Hamming(7,4) corrector.
// Optional per-source corrected-word counters: define HAMMING_ERRCNT_EN.
module hamming_dec_arbiter
   import hamming_pkg::*;
#(
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in0_valid,
   input  logic             in1_valid,
   output logic             in0_ready,
   output logic             in1_ready,
   input  logic [6:0]       in0_cw,
   input  logic [6:0]       in1_cw,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [3:0]       out_data,
   output logic [6:0]       out_cw,
   output logic [2:0]       out_syndrome,
   output logic             out_corrected,
   output logic             out_src,
   output logic [CNT_W-1:0] err_cnt0,
   output logic [CNT_W-1:0] err_cnt1
);

   dec_state_e r_state;
   logic       r_rr;
   cw_t        r_cw;
   logic       r_src;
   synd_t      r_synd;

   logic       r_out_valid;
   nibble_t    r_out_data;
   cw_t        r_out_cw;
   synd_t      r_out_synd;
   logic       r_out_corr;
   logic       r_out_src;

   logic       w_any_valid;
   logic       w_grant;
   logic       w_accept;
   cw_t        w_corr_cw;
   nibble_t    w_corr_data;
   logic       w_corr_flag;

   // Round-robin grant: on a tie the source that did not win last time goes
   always_comb begin
      w_any_valid = in0_valid | in1_valid;
      w_grant     = (in0_valid & in1_valid) ? ~r_rr : in1_valid;
      w_accept    = rst_n & (r_state == IDLE) & w_any_valid;
   end

   assign in0_ready = w_accept & ~w_grant;
   assign in1_ready = w_accept &  w_grant;

   correccion_error u_corr (
      .i_cw          (r_cw),
      .i_synd        (r_synd),
      .o_cw_c        (w_corr_cw),
      .o_data_c      (w_corr_data),
      .o_corrected_c (w_corr_flag)
   );

   // Sequencer: capture, syndrome, correct, present
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_rr        <= 1'b1;
         r_cw        <= '0;
         r_src       <= 1'b0;
         r_synd      <= '0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_cw    <= '0;
         r_out_synd  <= '0;
         r_out_corr  <= 1'b0;
         r_out_src   <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_cw    <= w_grant ? in1_cw : in0_cw;
                  r_src   <= w_grant;
                  r_rr    <= w_grant;
                  r_state <= SYND;
               end
            end
            SYND: begin
               r_synd  <= calc_syndrome(r_cw);
               r_state <= CORR;
            end
            CORR: begin
               r_out_cw    <= w_corr_cw;
               r_out_data  <= w_corr_data;
               r_out_synd  <= r_synd;
               r_out_corr  <= w_corr_flag;
               r_out_src   <= r_src;
               r_out_valid <= 1'b1;
               r_state     <= OUT;
            end
            OUT: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_state     <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign out_valid     = r_out_valid;
   assign out_data      = r_out_data;
   assign out_cw        = r_out_cw;
   assign out_syndrome  = r_out_synd;
   assign out_corrected = r_out_corr;
   assign out_src       = r_out_src;

`ifdef HAMMING_ERRCNT_EN
   logic [CNT_W-1:0] r_err_cnt0;
   logic [CNT_W-1:0] r_err_cnt1;
   logic             w_err_inc;

   assign w_err_inc = (r_state == OUT) & out_ready & r_out_corr;

   // Saturating count of corrected words per source, counted as each result leaves
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_err_cnt0 <= '0;
         r_err_cnt1 <= '0;
      end else begin
         if (w_err_inc & ~r_src & (r_err_cnt0 != {CNT_W{1'b1}})) begin
            r_err_cnt0 <= r_err_cnt0 + CNT_W'(1);
         end
         if (w_err_inc &  r_src & (r_err_cnt1 != {CNT_W{1'b1}})) begin
            r_err_cnt1 <= r_err_cnt1 + CNT_W'(1);
         end
      end
   end

   assign err_cnt0 = r_err_cnt0;
   assign err_cnt1 = r_err_cnt1;
`else
   assign err_cnt0 = '0;
   assign err_cnt1 = '0;
`endif

endmodule
